// File: rtl/line_window_buffer.sv
// line_window_buffer: KROWS x SEG_PIX line store, prefetching staging row.
// Define LWB_STALL_CNT_EN to add the stall_cnt WAIT-cycle counter output.
module line_window_buffer #(
  parameter int PIX_W   = 24,
  parameter int WORD_W  = 32,
  parameter int SEG_PIX = 8,
  parameter int KROWS   = 3,
  parameter int KCOLS   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           prime,
  input  logic [WORD_W-1:0]              rd_data,
  input  logic                           rd_valid,
  input  logic                           win_adv,
  output logic [KROWS*KCOLS*PIX_W-1:0]   win_data,
  output logic                           win_valid,
  output logic [$clog2(SEG_PIX)-1:0]     win_col,
  output logic                           need_row,
  output logic                           row_done,
  output logic                           busy,
  output logic                           err_ovf
`ifdef LWB_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_cnt
`endif
);

  localparam int CW = $clog2(SEG_PIX);
  localparam int SW = $clog2(SEG_PIX + 1);
  localparam int MW = $clog2(KROWS + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(SEG_PIX - KCOLS);
  localparam logic [MW-1:0] LAST_MV = MW'(KROWS - 1);
  localparam logic [SW-1:0] FULL = SW'(SEG_PIX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [KROWS-1:0][SEG_PIX-1:0][PIX_W-1:0] rows;
  logic [SEG_PIX-1:0][PIX_W-1:0]            staging;
  logic [SW-1:0]                            st_cnt;
  logic [MW-1:0]                            mv_cnt;
  logic                                     st_full;
  logic                                     do_move;
  logic                                     mv_inc;
  logic                                     col_inc;
  logic                                     col_clr;
  logic                                     acc;
  logic                                     drop;

  assign busy     = (state != S_IDLE);
  assign st_full  = (st_cnt == FULL);
  assign need_row = busy && !st_full;
  assign acc      = busy && rd_valid && !st_full && !prime;
  assign drop     = busy && rd_valid && st_full && !prime;

  if (WORD_W > PIX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^rd_data[WORD_W-1:PIX_W];
  end

  always_comb begin
    state_nxt = state;
    do_move   = 1'b0;
    mv_inc    = 1'b0;
    col_inc   = 1'b0;
    col_clr   = 1'b0;
    row_done  = 1'b0;
    win_valid = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_PRIME: begin
        if (st_full) begin
          do_move = 1'b1;
          mv_inc  = 1'b1;
          if (mv_cnt == LAST_MV) begin
            state_nxt = S_RUN;
            col_clr   = 1'b1;
          end
        end
      end
      S_RUN: begin
        win_valid = 1'b1;
        if (win_adv) begin
          if (win_col != LAST_COL) begin
            col_inc = 1'b1;
          end else begin
            row_done = 1'b1;
            if (st_full) begin
              do_move = 1'b1;
              col_clr = 1'b1;
            end else begin
              state_nxt = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (st_full) begin
          do_move   = 1'b1;
          col_clr   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Restart wins over everything in flight
    if (prime) begin
      state_nxt = S_PRIME;
      do_move   = 1'b0;
      mv_inc    = 1'b0;
      col_inc   = 1'b0;
      col_clr   = 1'b1;
      row_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rows    <= '0;
      staging <= '0;
      st_cnt  <= '0;
      mv_cnt  <= '0;
      win_col <= '0;
      err_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (prime) begin
        mv_cnt  <= '0;
        st_cnt  <= '0;
        err_ovf <= 1'b0;
      end else begin
        if (mv_inc) mv_cnt <= mv_cnt + 1'b1;
        if (do_move) st_cnt <= '0;
        else if (acc) st_cnt <= st_cnt + 1'b1;
        if (drop) err_ovf <= 1'b1;
      end
      if (acc) staging[st_cnt[CW-1:0]] <= rd_data[PIX_W-1:0];
      if (do_move) rows <= {rows[KROWS-2:0], staging};
      if (col_clr) win_col <= '0;
      else if (col_inc) win_col <= win_col + 1'b1;
    end
  end

  for (genvar t = 0; t < KROWS; t++) begin : g_wr
    for (genvar j = 0; j < KCOLS; j++) begin : g_wc
      logic [CW-1:0] cidx;
      assign cidx = win_col + CW'(j);
      assign win_data[(KROWS*KCOLS-1-t*KCOLS-j)*PIX_W +: PIX_W] =
        rows[KROWS-1-t][cidx];
    end
  end

`ifdef LWB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (prime) begin
      stall_cnt <= '0;
    end else if (state == S_WAIT && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: directed sequence with random pixels and gaps,
// checked against a row-list model of the window store.
module tb_line_window_buffer;
  localparam int PIX_W   = 24;
  localparam int WORD_W  = 32;
  localparam int SEG_PIX = 8;
  localparam int KROWS   = 3;
  localparam int KCOLS   = 3;
  localparam int WW      = KROWS * KCOLS * PIX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              prime;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              win_adv;
  logic [WW-1:0]     win_data;
  logic              win_valid;
  logic [2:0]        win_col;
  logic              need_row;
  logic              row_done;
  logic              busy;
  logic              err_ovf;
`ifdef LWB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int last_feed;
  int mrows [KROWS][SEG_PIX];
  int mstage [$];

  always #5 clk = ~clk;

  line_window_buffer #(
    .PIX_W(PIX_W), .WORD_W(WORD_W), .SEG_PIX(SEG_PIX),
    .KROWS(KROWS), .KCOLS(KCOLS)
  ) dut (
    .clk(clk), .rst(rst), .prime(prime),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .win_adv(win_adv), .win_data(win_data),
    .win_valid(win_valid), .win_col(win_col),
    .need_row(need_row), .row_done(row_done),
    .busy(busy), .err_ovf(err_ovf)
`ifdef LWB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(string tag, logic [WW-1:0] obs, logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  function automatic logic [WW-1:0] exp_win(int col);
    logic [WW-1:0] v;
    v = '0;
    for (int t = 0; t < KROWS; t++)
      for (int j = 0; j < KCOLS; j++)
        v = (v << PIX_W) | WW'(mrows[KROWS-1-t][col+j]);
    return v;
  endfunction

  function automatic void model_move();
    for (int r = KROWS - 1; r > 0; r--)
      for (int c = 0; c < SEG_PIX; c++)
        mrows[r][c] = mrows[r-1][c];
    for (int c = 0; c < SEG_PIX; c++)
      mrows[0][c] = mstage[c];
    mstage.delete();
  endfunction

  function automatic int rpix();
    return int'($urandom_range(0, 32'h00FF_FFFF));
  endfunction

  task automatic feed(int pix);
    int n;
    n = 0;
    while (!need_row && n < 20) begin
      rd_valid = 1'b0;
      cyc();
      n++;
    end
    chk("feed_need_row", need_row, 1);
    rd_valid  = 1'b1;
    rd_data   = {8'($urandom), 24'(pix)};
    last_feed = cycle;
    cyc();
    rd_valid = 1'b0;
    mstage.push_back(pix);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t_adv, mstall, n, guard, pix;
    rst = 1'b1; prime = 1'b0; rd_valid = 1'b0;
    win_adv = 1'b0; rd_data = '0;
    mstall = 0;
    cyc(); cyc();
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_need_row", need_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_win_data", win_data, 0);
    rst = 1'b0;

    prime = 1'b1; cyc(); prime = 1'b0;
    chk("prime_busy", busy, 1);
    chk("prime_need_row", need_row, 1);
    for (int i = 1; i <= 24; i++) begin
      feed(i);
      if (mstage.size() == SEG_PIX) model_move();
    end
    chk("prime_lat1_valid", win_valid, 0);
    cyc();
    chk("prime_lat2_valid", win_valid, 1);
    chk("prime_col", win_col, 0);
    chk("prime_win", win_data, exp_win(0));
    chk("prime_top_pix", win_data[WW-1 -: PIX_W], 1);

    for (int i = 0; i <= 8; i++) begin
      rd_valid = (i < 8);
      rd_data  = {8'($urandom), 24'(25 + i)};
      win_adv  = (i >= 3);
      chk("slide_valid", win_valid, 1);
      if (i >= 3) begin
        chk("slide_col", win_col, i - 3);
        chk("slide_win", win_data, exp_win(i - 3));
      end
      #1 chk("slide_row_done", row_done, i == 8);
      cyc();
      if (i < 8) mstage.push_back(25 + i);
    end
    rd_valid = 1'b0; win_adv = 1'b0;
    model_move();
    chk("pref_valid", win_valid, 1);
    chk("pref_col", win_col, 0);
    chk("pref_win", win_data, exp_win(0));

    for (int i = 0; i < 8; i++) begin
      pix = rpix();
      rd_valid = 1'b1;
      rd_data  = {8'($urandom), 24'(pix)};
      win_adv  = (i >= 2);
      #1 chk("same_row_done", row_done, i == 7);
      if (i == 7) t_adv = cycle;
      cyc();
      mstage.push_back(pix);
    end
    rd_valid = 1'b0; win_adv = 1'b0;
    mstall += 1;
    chk("same_wait_valid", win_valid, 0);
    chk("same_wait_need", need_row, 0);
    cyc();
    model_move();
    chk("same_valid", win_valid, 1);
    chk("same_win", win_data, exp_win(0));
`ifdef LWB_STALL_CNT_EN
    chk("same_stall", stall_cnt, mstall);
`endif

    n = 0; guard = 0;
    while (n < 6 && guard < 200) begin
      win_adv = 1'($urandom_range(0, 1));
      chk("rand_col", win_col, n);
      if (win_adv && n == 5) t_adv = cycle;
      #1 chk("rand_row_done", row_done, win_adv && n == 5);
      cyc();
      if (win_adv) n++;
      guard++;
    end
    win_adv = 1'b0;
    chk("rand_adv_count", n, 6);
    chk("np_valid", win_valid, 0);
    chk("np_need_row", need_row, 1);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      feed(rpix());
    end
    mstall += last_feed - t_adv + 1;
    chk("np_lat1_valid", win_valid, 0);
    cyc();
    model_move();
    chk("np_lat2_valid", win_valid, 1);
    chk("np_col", win_col, 0);
    chk("np_win", win_data, exp_win(0));
`ifdef LWB_STALL_CNT_EN
    chk("np_stall", stall_cnt, mstall);
`endif

    for (int i = 0; i < 8; i++) feed(rpix());
    chk("ovf_need_row", need_row, 0);
    chk("ovf_err_pre", err_ovf, 0);
    rd_valid = 1'b1;
    rd_data  = {8'($urandom), 24'(rpix())};
    cyc();
    rd_valid = 1'b0;
    chk("ovf_err", err_ovf, 1);
    for (int a = 0; a < 6; a++) begin
      win_adv = 1'b1;
      cyc();
    end
    win_adv = 1'b0;
    model_move();
    chk("ovf_valid", win_valid, 1);
    chk("ovf_win", win_data, exp_win(0));
    chk("ovf_err_sticky", err_ovf, 1);

    prime = 1'b1; cyc(); prime = 1'b0;
    chk("reprime_err", err_ovf, 0);
    chk("reprime_valid", win_valid, 0);
    chk("reprime_busy", busy, 1);
`ifdef LWB_STALL_CNT_EN
    chk("reprime_stall", stall_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
